sba_bus_arbiter: RTL and testbench
==================================

// Module: sba_bus_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single system-bus master port (req/gnt, valid/rdata
//   interface of the AXI adapter) between NUM_REQ requesters, e.g. debug SBA and boot DMA.
//   One outstanding transaction at a time; request fields registered at arbitration.
//   Response watchdog returns an error to the owner if the bus never answers.
// PARAMETERS
//   NUM_REQ     2     number of requesters (>=2)
//   ADDR_WIDTH  64    address width
//   DATA_WIDTH  64    data width; byte enables are DATA_WIDTH/8
//   TIMEOUT     1024  max cycles in WAIT before error; 0 disables watchdog
// PORTS
//   clk_i       in   1                  clock
//   rst_i       in   1                  synchronous reset, active-high
//   req_i       in   NUM_REQ            per-requester request, held high until gnt_o
//   we_i        in   NUM_REQ            per-requester write enable
//   addr_i      in   NUM_REQ*ADDR_WIDTH per-requester address (packed, req 0 in LSBs)
//   wdata_i     in   NUM_REQ*DATA_WIDTH per-requester write data
//   be_i        in   NUM_REQ*DATA_WIDTH/8 per-requester byte enables
//   size_i      in   NUM_REQ*2          per-requester log2 access size
//   gnt_o       out  NUM_REQ            one-hot grant pulse
//   valid_o     out  NUM_REQ            one-hot response pulse
//   err_o       out  NUM_REQ            one-hot timeout error pulse (coincides with valid_o)
//   rdata_o     out  DATA_WIDTH         shared response data, qualified by valid_o
//   busy_o      out  1                  state != IDLE
//   owner_o     out  $clog2(NUM_REQ)    index of current/last owner
//   m_req_o     out  1                  master request
//   m_we_o, m_addr_o, m_wdata_o, m_be_o, m_size_o  out  as per requester  registered fields
//   m_gnt_i     in   1                  master grant
//   m_valid_i   in   1                  master response valid
//   m_rdata_i   in   DATA_WIDTH         master read data
// BEHAVIOUR
//   - Reset: state IDLE, rr pointer = NUM_REQ-1 (req 0 highest first), counter 0, owner 0,
//     all m_* field registers 0; every output 0.
//   - FSM: IDLE, REQ, WAIT, DRAIN.
//   - IDLE: if any req_i, winner = first set bit scanning ptr+1, ptr+2, ... mod NUM_REQ;
//     latch owner and its we/addr/wdata/be/size; -> REQ. m_req_o rises next cycle
//     (1 cycle arbitration latency). m_valid_i in IDLE ignored.
//   - REQ: m_req_o=1, fields stable. gnt_o[owner] = m_gnt_i (combinational).
//     m_gnt_i & m_valid_i same cycle -> complete as below, -> IDLE; m_gnt_i only -> WAIT.
//     No timeout in REQ; req_i deassertion in REQ is ignored (transaction runs to end).
//   - WAIT: m_req_o=0. counter increments each cycle. m_valid_i -> valid_o[owner]=1,
//     rdata_o=m_rdata_i (combinational), ptr<=owner, counter<=0, -> IDLE.
//     TIMEOUT!=0 and counter==TIMEOUT-1 with no m_valid_i -> valid_o[owner]=err_o[owner]=1,
//     rdata_o=0, ptr<=owner, -> DRAIN. m_valid_i on the timeout cycle wins (normal completion).
//   - DRAIN: no arbitration; wait for late m_valid_i, discard (no valid_o), -> IDLE.
//   - rdata_o = 0 whenever no valid_o bit set. At most one bit of gnt_o/valid_o/err_o set.
//   - Fairness: a continuously requesting input waits at most NUM_REQ-1 transactions.
//   - Counter width $clog2(TIMEOUT+1); saturating never needed (cleared on exit of WAIT).
//   - rst_i mid-transaction: immediate return to reset state; master response for the
//     aborted transaction arrives in IDLE and is ignored.
// TESTING
//   1. Single req0 write addr 0x1000, be 0xFF; m_gnt_i 2 cyc later, m_valid_i 3 cyc later
//      -> m_req_o at t+1, gnt_o=01 pulse, valid_o=01 pulse, ptr=0.
//   2. req0 and req1 held high, 4 transactions -> owners 0,1,0,1; gnt_o never 11.
//   3. m_gnt_i & m_valid_i same cycle, m_rdata_i=0xDEADBEEF -> valid_o[owner]=1,
//      rdata_o=0xDEADBEEF that cycle, FSM in IDLE next cycle.
//   4. TIMEOUT=8, no m_valid_i after grant -> valid_o=err_o=owner pulse 8 cyc after WAIT
//      entry, rdata_o=0; late m_valid_i dropped; next req arbitrated after it.
//   5. rst_i asserted in WAIT -> all outputs 0 next cycle, busy_o=0; following m_valid_i
//      produces no valid_o; next request from req0 wins.
//   6. Read via req1, size_i=2'b10 addr 0x2004 -> m_addr_o=0x2004, m_size_o=2, m_we_o=0
//      stable through REQ even if req1 inputs change after arbitration.

Source files
------------

// File: rtl/sba_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus master port among NUM_REQ requesters.
// One outstanding transaction; response watchdog returns an error to the owner.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i, we_i          per-requester request (held until gnt_o) and write enable
//   addr_i, wdata_i      per-requester address / write data (req 0 in LSBs)
//   be_i, size_i         per-requester byte enables / log2 access size
//   gnt_o, valid_o       one-hot grant pulse / response pulse
//   err_o, rdata_o       one-hot timeout error / shared response data
//   busy_o, owner_o      not idle / index of current or last owner
//   m_req_o .. m_size_o  master request and registered request fields
//   m_gnt_i, m_valid_i   master grant / response valid
//   m_rdata_i            master read data
module sba_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_REQ*2-1:0]              size_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                valid_o,
  output logic [NUM_REQ-1:0]                err_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        owner_o,
  output logic                              m_req_o,
  output logic                              m_we_o,
  output logic [ADDR_WIDTH-1:0]             m_addr_o,
  output logic [DATA_WIDTH-1:0]             m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           m_be_o,
  output logic [1:0]                        m_size_o,
  input  logic                              m_gnt_i,
  input  logic                              m_valid_i,
  input  logic [DATA_WIDTH-1:0]             m_rdata_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          latch;
  logic [IW-1:0] win;
  logic          found;
  int            idx;
  logic [NUM_REQ-1:0] oh;

  // Scan ptr+1, ptr+2, ... so the last owner has lowest priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_i[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign oh      = NUM_REQ'(1) << owner_q;
  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NUM_REQ - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      m_we_o    <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_be_o    <= '0;
      m_size_o  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        m_we_o    <= we_i[win];
        m_addr_o  <= addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        m_wdata_o <= wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
        m_be_o    <= be_i[win*BW +: BW];
        m_size_o  <= size_i[win*2 +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    m_req_o = 1'b0;
    gnt_o   = '0;
    valid_o = '0;
    err_o   = '0;
    rdata_o = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = win;
          latch   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        m_req_o = 1'b1;
        if (m_gnt_i) begin
          gnt_o = oh;
          if (m_valid_i) begin
            valid_o = oh;
            rdata_o = m_rdata_i;
            ptr_d   = owner_q;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A response on the final watchdog cycle still completes normally.
        if (m_valid_i) begin
          valid_o = oh;
          rdata_o = m_rdata_i;
          ptr_d   = owner_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          valid_o = oh;
          err_o   = oh;
          ptr_d   = owner_q;
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        // Swallow the late response of the timed-out transaction.
        if (m_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sba_bus_arbiter.sv
// Scoreboard bench for sba_bus_arbiter: directed reset/grant cases,
// then randomized round-robin epochs against a queue-based model.
module tb_sba_bus_arbiter;

  localparam int N   = 3;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, we_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*8-1:0]  be_i;
  logic [N*2-1:0]  size_i;
  logic [N-1:0]    gnt_o, valid_o, err_o;
  logic [DW-1:0]   rdata_o;
  logic            busy_o;
  logic [1:0]      owner_o;
  logic            m_req_o, m_we_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;
  logic [7:0]      m_be_o;
  logic [1:0]      m_size_o;
  logic            m_gnt_i, m_valid_i;
  logic [DW-1:0]   m_rdata_i;

  sba_bus_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .be_i(be_i), .size_i(size_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .err_o(err_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .owner_o(owner_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_size_o(m_size_o),
    .m_gnt_i(m_gnt_i), .m_valid_i(m_valid_i), .m_rdata_i(m_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          own;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  size;
    logic        err;
    logic [63:0] rdata;
    int          rlat;
  } exp_t;

  typedef struct {
    int          gdly;
    int          rlat;
    logic        tmo;
    logic [63:0] rdata;
    int          late;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   auto_on  = 1'b0;
  bit   abort    = 1'b0;
  bit   mon_have = 1'b0;
  int   sphase   = 0;
  int   mptr;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic set_fields(input int i, input logic we, input logic [63:0] a,
                            input logic [63:0] d, input logic [7:0] b,
                            input logic [1:0] s);
    we_i[i]              = we;
    addr_i[i*AW +: AW]   = a;
    wdata_i[i*DW +: DW]  = d;
    be_i[i*8 +: 8]       = b;
    size_i[i*2 +: 2]     = s;
  endtask

  // Bus slave: grants and answers each transaction as scripted.
  initial begin
    slv_t scur;
    int   scnt;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!auto_on) continue;
      m_gnt_i   = 1'b0;
      m_valid_i = 1'b0;
      m_rdata_i = {$urandom, $urandom};
      if (sphase == 0) begin
        if (m_req_o && slv_q.size() > 0) begin
          scur   = slv_q.pop_front();
          scnt   = 0;
          sphase = 1;
        end else if (!busy_o && $urandom_range(0, 7) == 0) begin
          m_valid_i = 1'b1;
        end
      end else if (sphase == 2) begin
        scnt++;
        if (!scur.tmo && scnt == scur.rlat) begin
          m_valid_i = 1'b1;
          m_rdata_i = scur.rdata;
          sphase    = 0;
        end else if (scur.tmo && scnt == TMO + scur.late) begin
          m_valid_i = 1'b1;
          sphase    = 0;
        end
      end
      if (sphase == 1) begin
        if (scnt == scur.gdly) begin
          m_gnt_i = 1'b1;
          if (!scur.tmo && scur.rlat == 0) begin
            m_valid_i = 1'b1;
            m_rdata_i = scur.rdata;
            sphase    = 0;
          end else begin
            sphase = 2;
            scnt   = 0;
          end
        end else begin
          scnt++;
        end
      end
    end
  end

  // Monitor: pops expected transactions and checks every output each cycle.
  initial begin
    exp_t        cur;
    bit          gseen;
    int          lat;
    bit          resp;
    logic [N-1:0] eg;
    gseen = 1'b0;
    lat   = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!auto_on) continue;
      if (m_req_o && !mon_have) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexp_txn got=owner%0d exp=none", owner_o);
        end else begin
          cur      = exp_q.pop_front();
          mon_have = 1'b1;
          gseen    = 1'b0;
          lat      = 0;
          chk("owner", 160'(owner_o), 160'(cur.own));
        end
      end
      chk("m_req", 160'(m_req_o), 160'(mon_have && !gseen));
      if (mon_have && !gseen)
        chk("fields", {m_we_o, m_addr_o, m_wdata_o, m_be_o, m_size_o},
            {cur.we, cur.addr, cur.wdata, cur.be, cur.size});
      eg = (mon_have && !gseen && m_gnt_i) ? oh(cur.own) : '0;
      chk("gnt", 160'(gnt_o), 160'(eg));
      if (mon_have && !gseen && m_gnt_i) begin
        gseen = 1'b1;
        lat   = 0;
      end
      resp = mon_have && gseen && (lat == cur.rlat);
      chk("valid", 160'(valid_o), 160'(resp ? oh(cur.own) : '0));
      chk("err", 160'(err_o), 160'((resp && cur.err) ? oh(cur.own) : '0));
      chk("rdata", 160'(rdata_o), 160'((resp && !cur.err) ? cur.rdata : 64'd0));
      if (resp) mon_have = 1'b0;
      else if (mon_have && gseen) lat++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] s;
    int           ord[$];
    exp_t         x;
    slv_t         y;
    int           n;
    bit           done;
    int           ix;

    rst_i     = 1'b1;
    req_i     = '0;
    we_i      = '0;
    addr_i    = '0;
    wdata_i   = '0;
    be_i      = '0;
    size_i    = '0;
    m_gnt_i   = 1'b0;
    m_valid_i = 1'b0;
    m_rdata_i = '0;
    repeat (3) @(posedge clk);

    @(negedge clk);
    m_valid_i = 1'b1;
    m_rdata_i = 64'hAAAA;
    #2;
    chk("rst_busy", 160'(busy_o), 0);
    chk("rst_mreq", 160'(m_req_o), 0);
    chk("rst_owner", 160'(owner_o), 0);
    chk("rst_addr", 160'(m_addr_o), 0);
    chk("rst_we", 160'(m_we_o), 0);
    chk("rst_valid", 160'(valid_o), 0);
    chk("rst_rdata", 160'(rdata_o), 0);
    rst_i     = 1'b0;
    m_valid_i = 1'b0;

    // Single write from req0
    set_fields(0, 1'b1, 64'h1000, 64'h0123_4567_89ab_cdef, 8'hFF, 2'b11);
    req_i = 3'b001;
    #2;
    chk("t1_pre_mreq", 160'(m_req_o), 0);
    @(negedge clk);
    #2;
    chk("t1_mreq", 160'(m_req_o), 1);
    chk("t1_addr", 160'(m_addr_o), 160'h1000);
    chk("t1_be", 160'(m_be_o), 160'hFF);
    chk("t1_we", 160'(m_we_o), 1);
    chk("t1_owner", 160'(owner_o), 0);
    chk("t1_nognt", 160'(gnt_o), 0);
    @(negedge clk);
    m_gnt_i = 1'b1;
    #2;
    chk("t1_gnt", 160'(gnt_o), 160'(3'b001));
    req_i = '0;
    @(negedge clk);
    m_gnt_i = 1'b0;
    #2;
    chk("t1_wait_mreq", 160'(m_req_o), 0);
    chk("t1_wait_busy", 160'(busy_o), 1);
    @(negedge clk);
    m_valid_i = 1'b1;
    m_rdata_i = 64'h1234_5678_9abc_def0;
    #2;
    chk("t1_valid", 160'(valid_o), 160'(3'b001));
    chk("t1_rdata", 160'(rdata_o), 160'h1234_5678_9abc_def0);
    chk("t1_err", 160'(err_o), 0);
    @(negedge clk);
    m_valid_i = 1'b0;
    #2;
    chk("t1_idle", 160'(busy_o), 0);

    // Read from req1 (ptr now 0), fields scrambled after arbitration
    set_fields(1, 1'b0, 64'h2004, 64'h0, 8'h0F, 2'b10);
    set_fields(0, 1'b1, 64'h3000, 64'h77, 8'h01, 2'b00);
    req_i = 3'b011;
    @(negedge clk);
    #2;
    chk("t6_owner", 160'(owner_o), 1);
    chk("t6_addr", 160'(m_addr_o), 160'h2004);
    chk("t6_size", 160'(m_size_o), 2);
    chk("t6_we", 160'(m_we_o), 0);
    set_fields(1, 1'b1, 64'hFFFF_0000, 64'h99, 8'hF0, 2'b01);
    @(negedge clk);
    m_gnt_i = 1'b1;
    #2;
    chk("t6_addr_hold", 160'(m_addr_o), 160'h2004);
    chk("t6_size_hold", 160'(m_size_o), 2);
    chk("t6_we_hold", 160'(m_we_o), 0);
    chk("t5_gnt", 160'(gnt_o), 160'(3'b010));
    req_i[1] = 1'b0;
    @(negedge clk);
    m_gnt_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    req_i = 3'b011;
    #2;
    chk("t5_busy", 160'(busy_o), 0);
    chk("t5_mreq", 160'(m_req_o), 0);
    chk("t5_owner", 160'(owner_o), 0);
    chk("t5_addr", 160'(m_addr_o), 0);
    chk("t5_valid", 160'(valid_o), 0);
    @(negedge clk);
    m_valid_i = 1'b1;
    m_rdata_i = 64'h5555;
    #2;
    chk("t5_stray", 160'(valid_o), 0);
    chk("t5_rdata0", 160'(rdata_o), 0);
    chk("t5_win", 160'(owner_o), 0);
    chk("t5_addr0", 160'(m_addr_o), 160'h3000);
    @(negedge clk);
    m_gnt_i   = 1'b1;
    m_valid_i = 1'b1;
    m_rdata_i = 64'hDEADBEEF;
    #2;
    chk("t3_gnt", 160'(gnt_o), 160'(3'b001));
    chk("t3_valid", 160'(valid_o), 160'(3'b001));
    chk("t3_rdata", 160'(rdata_o), 160'hDEADBEEF);
    req_i = '0;
    @(negedge clk);
    m_gnt_i   = 1'b0;
    m_valid_i = 1'b0;
    #2;
    chk("t3_idle", 160'(busy_o), 0);
    mptr    = 0;
    auto_on = 1'b1;

    // Random epochs: a set of requesters rises together; each is served
    // once, in rotation order starting after the last owner.
    for (int e = 0; e < 150 && !abort; e++) begin
      s = N'($urandom_range(1, (1 << N) - 1));
      ord.delete();
      for (int k = 1; k <= N; k++) begin
        ix = (mptr + k) % N;
        if (s[ix]) ord.push_back(ix);
      end
      foreach (ord[j]) begin
        x.own   = ord[j];
        x.we    = 1'($urandom_range(0, 1));
        x.addr  = {$urandom, $urandom};
        x.wdata = {$urandom, $urandom};
        x.be    = 8'($urandom);
        x.size  = 2'($urandom);
        y.gdly  = $urandom_range(0, 3);
        y.tmo   = ($urandom_range(0, 4) == 0);
        y.rlat  = $urandom_range(0, TMO);
        y.late  = $urandom_range(1, 4);
        y.rdata = {$urandom, $urandom};
        x.err   = y.tmo;
        x.rlat  = y.tmo ? TMO : y.rlat;
        x.rdata = y.rdata;
        set_fields(x.own, x.we, x.addr, x.wdata, x.be, x.size);
        exp_q.push_back(x);
        slv_q.push_back(y);
      end
      mptr = ord[ord.size() - 1];
      @(negedge clk);
      #3;
      req_i = s;
      n     = 0;
      done  = 1'b0;
      while (!done && !abort) begin
        @(negedge clk);
        #3;
        req_i = req_i & ~gnt_o;
        if (m_req_o)
          set_fields(int'(owner_o), 1'($urandom), {$urandom, $urandom},
                     {$urandom, $urandom}, 8'($urandom), 2'($urandom));
        done = (req_i == '0) && (exp_q.size() == 0) && !mon_have &&
               (sphase == 0) && !busy_o;
        n++;
        if (n > 200) begin
          checks++;
          failures++;
          $display("FAIL epoch_%0d got=stuck exp=served pending=%0d", e,
                   exp_q.size());
          abort = 1'b1;
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
